// File: rtl/fp_issue_ctrl.sv
// Issue/retire controller for an out-of-order-completing FPU: tracks destination
// registers in flight, stalls on RAW/WAW hazards, and maps result tags to write-back.
module fp_issue_ctrl #(
    parameter int MAX_INFLIGHT = 4,
    parameter int TAG_W        = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic [4:0]       frs1_i,
    input  logic [4:0]       frs2_i,
    input  logic [4:0]       frs3_i,
    input  logic [4:0]       frd_i,
    input  logic             use_rs1_i,
    input  logic             use_rs2_i,
    input  logic             use_rs3_i,
    input  logic             wr_frd_i,

    input  logic             instr_valid_i,
    output logic             instr_ready_o,

    output logic             fpu_valid_o,
    input  logic             fpu_ready_i,
    output logic [TAG_W-1:0] fpu_tag_o,

    input  logic             fpu_out_valid_i,
    output logic             fpu_out_ready_o,
    input  logic [TAG_W-1:0] fpu_tag_i,

    output logic             wb_we_o,
    output logic [4:0]       wb_addr_o,

    input  logic             flush_i,
    output logic             fpu_flush_o,

    output logic             busy_o,
    output logic             err_o
);

    // state    | meaning
    // ST_IDLE  | nothing in flight
    // ST_BUSY  | at least one op outstanding in the FPU
    // ST_FLUSH | one-cycle flush: FPU told to drop work, all tracking cleared
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int CNT_W = TAG_W + 1;

    state_t            state;
    state_t            state_next;
    logic [31:0]       pending;
    logic [31:0]       pending_set;
    logic [31:0]       pending_clr;
    logic [4:0]        tbl_rd [MAX_INFLIGHT];
    logic [MAX_INFLIGHT-1:0] tbl_wr;
    logic [MAX_INFLIGHT-1:0] tbl_alloc;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;
    logic [TAG_W-1:0]  ptr;
    logic              err;

    logic              hazard;
    logic              can_issue;
    logic              issue;
    logic              retire;
    logic              retire_hit;
    logic              retire_miss;

    // Hazard uses the registered scoreboard only; a result retiring this cycle
    // does not release a dependent op until the next cycle.
    always_comb begin
        hazard = (use_rs1_i & pending[frs1_i])
               | (use_rs2_i & pending[frs2_i])
               | (use_rs3_i & pending[frs3_i])
               | (wr_frd_i  & pending[frd_i]);
    end

    always_comb begin
        can_issue = instr_valid_i
                  & ~hazard
                  & (count < CNT_W'(MAX_INFLIGHT))
                  & (state != ST_FLUSH)
                  & ~flush_i
                  & ~tbl_alloc[ptr]
                  & ~rst_i;
        issue       = can_issue & fpu_ready_i;
        retire      = fpu_out_valid_i & fpu_out_ready_o;
        retire_hit  = retire &  tbl_alloc[fpu_tag_i];
        retire_miss = retire & ~tbl_alloc[fpu_tag_i];
    end

    always_comb begin
        fpu_valid_o     = can_issue;
        instr_ready_o   = issue;
        fpu_tag_o       = rst_i ? '0 : ptr;
        fpu_out_ready_o = ~rst_i & (state != ST_FLUSH);
        wb_we_o         = retire_hit & tbl_wr[fpu_tag_i];
        wb_addr_o       = wb_we_o ? tbl_rd[fpu_tag_i] : 5'd0;
        fpu_flush_o     = ~rst_i & (state == ST_FLUSH);
        busy_o          = ~rst_i & (state != ST_IDLE);
        err_o           = err;
    end

    // Set is applied after clear so an issue wins over a same-cycle retire.
    always_comb begin
        pending_set = '0;
        pending_clr = '0;
        if (issue && wr_frd_i) begin
            pending_set = 32'd1 << frd_i;
        end
        if (wb_we_o) begin
            pending_clr = 32'd1 << tbl_rd[fpu_tag_i];
        end
    end

    always_comb begin
        count_next = count;
        if (issue && !retire_hit) begin
            count_next = count + CNT_W'(1);
        end else if (!issue && retire_hit) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (issue) state_next = ST_BUSY;
            ST_BUSY:  if (count_next == '0) state_next = ST_IDLE;
            ST_FLUSH: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (flush_i) begin
            state_next = ST_FLUSH;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_IDLE;
            pending   <= '0;
            tbl_wr    <= '0;
            tbl_alloc <= '0;
            count     <= '0;
            ptr       <= '0;
            err       <= 1'b0;
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                tbl_rd[i] <= 5'd0;
            end
        end else begin
            state <= state_next;
            if (retire_miss) begin
                err <= 1'b1;
            end
            if (state == ST_FLUSH) begin
                pending   <= '0;
                tbl_wr    <= '0;
                tbl_alloc <= '0;
                count     <= '0;
                ptr       <= '0;
                for (int i = 0; i < MAX_INFLIGHT; i++) begin
                    tbl_rd[i] <= 5'd0;
                end
            end else begin
                pending <= (pending & ~pending_clr) | pending_set;
                count   <= count_next;
                if (retire_hit) begin
                    tbl_alloc[fpu_tag_i] <= 1'b0;
                end
                // A free ptr slot is required to issue, so it never collides with the retiring tag.
                if (issue) begin
                    tbl_rd[ptr]    <= frd_i;
                    tbl_wr[ptr]    <= wr_frd_i;
                    tbl_alloc[ptr] <= 1'b1;
                    ptr            <= ptr + TAG_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Bench for fp_issue_ctrl: directed issue/retire scenarios with a write-back
// scoreboard of expected results keyed by the tags the bench expects to be issued.
module tb_fp_issue_ctrl;

    localparam int MAX_INFLIGHT = 4;
    localparam int TAG_W        = 2;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic [4:0]       frs1_i, frs2_i, frs3_i, frd_i;
    logic             use_rs1_i, use_rs2_i, use_rs3_i, wr_frd_i;
    logic             instr_valid_i;
    logic             instr_ready_o;
    logic             fpu_valid_o;
    logic             fpu_ready_i;
    logic [TAG_W-1:0] fpu_tag_o;
    logic             fpu_out_valid_i;
    logic             fpu_out_ready_o;
    logic [TAG_W-1:0] fpu_tag_i;
    logic             wb_we_o;
    logic [4:0]       wb_addr_o;
    logic             flush_i;
    logic             fpu_flush_o;
    logic             busy_o;
    logic             err_o;

    fp_issue_ctrl #(.MAX_INFLIGHT(MAX_INFLIGHT), .TAG_W(TAG_W)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .frs1_i          (frs1_i),
        .frs2_i          (frs2_i),
        .frs3_i          (frs3_i),
        .frd_i           (frd_i),
        .use_rs1_i       (use_rs1_i),
        .use_rs2_i       (use_rs2_i),
        .use_rs3_i       (use_rs3_i),
        .wr_frd_i        (wr_frd_i),
        .instr_valid_i   (instr_valid_i),
        .instr_ready_o   (instr_ready_o),
        .fpu_valid_o     (fpu_valid_o),
        .fpu_ready_i     (fpu_ready_i),
        .fpu_tag_o       (fpu_tag_o),
        .fpu_out_valid_i (fpu_out_valid_i),
        .fpu_out_ready_o (fpu_out_ready_o),
        .fpu_tag_i       (fpu_tag_i),
        .wb_we_o         (wb_we_o),
        .wb_addr_o       (wb_addr_o),
        .flush_i         (flush_i),
        .fpu_flush_o     (fpu_flush_o),
        .busy_o          (busy_o),
        .err_o           (err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       we;
        logic [4:0] addr;
    } wb_t;

    wb_t        wb_q [$];
    logic [4:0] sb_rd    [MAX_INFLIGHT];
    logic       sb_wr    [MAX_INFLIGHT];
    logic       sb_alloc [MAX_INFLIGHT];
    logic       in_flush = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        frs1_i = 5'd0; frs2_i = 5'd0; frs3_i = 5'd0; frd_i = 5'd0;
        use_rs1_i = 1'b0; use_rs2_i = 1'b0; use_rs3_i = 1'b0; wr_frd_i = 1'b0;
        instr_valid_i = 1'b0;
        fpu_ready_i = 1'b1;
        fpu_out_valid_i = 1'b0;
        fpu_tag_i = '0;
        flush_i = 1'b0;
    endtask

    task automatic clear_sb();
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
            sb_alloc[i] = 1'b0;
            sb_wr[i]    = 1'b0;
            sb_rd[i]    = 5'd0;
        end
    endtask

    task automatic set_op(input logic [4:0] rs1, input logic u1, input logic [4:0] rd, input logic wr);
        instr_valid_i = 1'b1;
        frs1_i = rs1; use_rs1_i = u1;
        frs2_i = 5'd0; use_rs2_i = 1'b0;
        frs3_i = 5'd0; use_rs3_i = 1'b0;
        frd_i = rd; wr_frd_i = wr;
    endtask

    // Expected write-back is fixed at the moment the result is offered.
    task automatic drive_retire(input logic [TAG_W-1:0] tag);
        wb_t e;
        fpu_out_valid_i = 1'b1;
        fpu_tag_i = tag;
        if (rst_i || in_flush || !sb_alloc[tag]) begin
            e.we = 1'b0; e.addr = 5'd0;
        end else begin
            e.we = sb_wr[tag];
            e.addr = sb_wr[tag] ? sb_rd[tag] : 5'd0;
            sb_alloc[tag] = 1'b0;
        end
        wb_q.push_back(e);
    endtask

    task automatic mid();
        wb_t e;
        @(negedge clk_i);
        if (fpu_out_valid_i) begin
            if (wb_q.size() == 0) begin
                check_val("wb_unexpected", {31'd0, wb_we_o}, 32'd0);
            end else begin
                e = wb_q.pop_front();
                check_val("wb_we", {31'd0, wb_we_o}, {31'd0, e.we});
                check_val("wb_addr", {27'd0, wb_addr_o}, {27'd0, e.addr});
            end
        end else begin
            check_val("wb_idle", {31'd0, wb_we_o}, 32'd0);
        end
    endtask

    task automatic fin();
        @(posedge clk_i);
        #1;
        clear_inputs();
    endtask

    task automatic expect_issue(input string name, input logic [TAG_W-1:0] tag);
        check_val(name, {31'd0, instr_ready_o}, 32'd1);
        check_val({name, "_tag"}, {30'd0, fpu_tag_o}, {30'd0, tag});
        sb_rd[tag] = frd_i;
        sb_wr[tag] = wr_frd_i;
        sb_alloc[tag] = 1'b1;
    endtask

    task automatic expect_stall(input string name);
        check_val(name, {31'd0, instr_ready_o}, 32'd0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        clear_inputs();
        clear_sb();
        fin();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        clear_inputs();
        clear_sb();
        fin();
        // Outputs under reset, with a request and a result both offered.
        set_op(5'd1, 1'b0, 5'd2, 1'b1);
        drive_retire(2'd1);
        mid();
        check_val("rst_instr_ready", {31'd0, instr_ready_o}, 32'd0);
        check_val("rst_fpu_valid", {31'd0, fpu_valid_o}, 32'd0);
        check_val("rst_out_ready", {31'd0, fpu_out_ready_o}, 32'd0);
        check_val("rst_busy", {31'd0, busy_o}, 32'd0);
        check_val("rst_flush", {31'd0, fpu_flush_o}, 32'd0);
        check_val("rst_tag", {30'd0, fpu_tag_o}, 32'd0);
        check_val("rst_err", {31'd0, err_o}, 32'd0);
        fin();
        rst_i = 1'b0;
        mid();
        check_val("idle_out_ready", {31'd0, fpu_out_ready_o}, 32'd1);
        check_val("idle_busy", {31'd0, busy_o}, 32'd0);
        fin();

        // RAW stall on f5 until its producer retires.
        set_op(5'd0, 1'b0, 5'd5, 1'b1);
        mid(); expect_issue("raw_prod", 2'd0); fin();
        for (int i = 0; i < 2; i++) begin
            set_op(5'd5, 1'b1, 5'd6, 1'b1);
            mid(); expect_stall("raw_stall");
            check_val("raw_busy", {31'd0, busy_o}, 32'd1);
            fin();
        end
        set_op(5'd5, 1'b1, 5'd6, 1'b1);
        drive_retire(2'd0);
        mid(); expect_stall("raw_no_bypass"); fin();
        set_op(5'd5, 1'b1, 5'd6, 1'b1);
        mid(); expect_issue("raw_after", 2'd1); fin();
        drive_retire(2'd1);
        mid(); fin();
        mid(); check_val("raw_idle", {31'd0, busy_o}, 32'd0); fin();

        // Fill all tags, fifth blocks until one retire has been registered.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_op(5'd0, 1'b0, 5'(10 + i), 1'b1);
            mid(); expect_issue("fill", 2'(i)); fin();
        end
        set_op(5'd0, 1'b0, 5'd20, 1'b1);
        mid(); expect_stall("full_stall");
        check_val("full_valid", {31'd0, fpu_valid_o}, 32'd0);
        check_val("full_busy", {31'd0, busy_o}, 32'd1);
        fin();
        set_op(5'd0, 1'b0, 5'd20, 1'b1);
        drive_retire(2'd0);
        mid(); expect_stall("full_same_cycle"); fin();
        set_op(5'd0, 1'b0, 5'd20, 1'b1);
        mid(); expect_issue("full_next", 2'd0); fin();

        // Drain to two in flight, then issue and retire together.
        drive_retire(2'd1); mid(); fin();
        drive_retire(2'd2); mid(); fin();
        set_op(5'd11, 1'b1, 5'd7, 1'b1);
        drive_retire(2'd3);
        mid(); expect_issue("swap_issue", 2'd1); fin();
        set_op(5'd7, 1'b1, 5'd8, 1'b1);
        mid(); expect_stall("swap_pending_set"); fin();
        set_op(5'd13, 1'b1, 5'd9, 1'b1);
        mid(); expect_issue("swap_pending_clr", 2'd2); fin();
        drive_retire(2'd0); mid(); fin();
        drive_retire(2'd1); mid(); fin();
        mid(); check_val("drain_busy_1", {31'd0, busy_o}, 32'd1); fin();
        drive_retire(2'd2); mid(); fin();
        mid(); check_val("drain_idle", {31'd0, busy_o}, 32'd0); fin();

        // Flush with three in flight.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_op(5'd0, 1'b0, 5'(1 + i), 1'b1);
            mid(); expect_issue("pre_flush", 2'(i)); fin();
        end
        set_op(5'd30, 1'b0, 5'd30, 1'b1);
        flush_i = 1'b1;
        mid(); expect_stall("flush_req_block"); fin();
        in_flush = 1'b1;
        set_op(5'd0, 1'b0, 5'd30, 1'b1);
        drive_retire(2'd0);
        mid();
        check_val("flush_pulse", {31'd0, fpu_flush_o}, 32'd1);
        check_val("flush_out_ready", {31'd0, fpu_out_ready_o}, 32'd0);
        expect_stall("flush_block");
        fin();
        in_flush = 1'b0;
        clear_sb();
        set_op(5'd1, 1'b1, 5'd2, 1'b1);
        mid();
        check_val("flush_pulse_end", {31'd0, fpu_flush_o}, 32'd0);
        check_val("flush_busy_low", {31'd0, busy_o}, 32'd0);
        expect_issue("post_flush", 2'd0);
        fin();

        // Unallocated tag raises a sticky error.
        do_reset();
        drive_retire(2'd3);
        mid(); fin();
        for (int i = 0; i < 3; i++) begin
            mid(); check_val("err_sticky", {31'd0, err_o}, 32'd1); fin();
        end
        set_op(5'd0, 1'b0, 5'd4, 1'b1);
        mid(); expect_issue("err_issue", 2'd0); fin();
        drive_retire(2'd0);
        mid(); fin();
        mid(); check_val("err_still", {31'd0, err_o}, 32'd1); fin();

        // Reset mid-operation with two ops in flight.
        do_reset();
        mid(); check_val("err_cleared", {31'd0, err_o}, 32'd0); fin();
        set_op(5'd0, 1'b0, 5'd4, 1'b1);
        mid(); expect_issue("pre_rst_a", 2'd0); fin();
        set_op(5'd0, 1'b0, 5'd5, 1'b1);
        mid(); expect_issue("pre_rst_b", 2'd1); fin();
        rst_i = 1'b1;
        set_op(5'd0, 1'b0, 5'd6, 1'b1);
        flush_i = 1'b1;
        drive_retire(2'd0);
        mid();
        check_val("midrst_ready", {31'd0, instr_ready_o}, 32'd0);
        check_val("midrst_valid", {31'd0, fpu_valid_o}, 32'd0);
        check_val("midrst_out_ready", {31'd0, fpu_out_ready_o}, 32'd0);
        check_val("midrst_flush", {31'd0, fpu_flush_o}, 32'd0);
        check_val("midrst_tag", {30'd0, fpu_tag_o}, 32'd0);
        fin();
        clear_sb();
        rst_i = 1'b1;
        mid();
        check_val("midrst_busy", {31'd0, busy_o}, 32'd0);
        fin();
        rst_i = 1'b0;
        set_op(5'd4, 1'b1, 5'd5, 1'b1);
        mid(); expect_issue("post_rst", 2'd0);
        check_val("post_rst_busy", {31'd0, busy_o}, 32'd0);
        fin();
        drive_retire(2'd1);
        mid(); fin();
        check_val("post_rst_err", {31'd0, err_o}, 32'd1);

        check_val("wb_q_drained", wb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
